// File: rtl/hmem_arbiter_if.sv
// Bundle of the I-cache, D-cache and higher-memory request/response signals
// seen by hmem_arbiter. The slave modport is the arbiter's view; master is the surroundings.
interface hmem_arbiter_if #(
  parameter int XLEN = 32
);
  logic            i_req_valid;
  logic [1:0]      i_req_size;
  logic [XLEN-1:0] i_req_address;
  logic            i_req_fulfilled;
  logic [XLEN-1:0] i_req_loaded_word;

  logic            d_req_valid;
  logic            d_req_operation;
  logic [1:0]      d_req_size;
  logic [XLEN-1:0] d_req_address;
  logic [XLEN-1:0] d_req_store_word;
  logic            d_req_fulfilled;
  logic [XLEN-1:0] d_req_loaded_word;

  logic            mem_req_valid;
  logic            mem_req_operation;
  logic [1:0]      mem_req_size;
  logic [XLEN-1:0] mem_req_address;
  logic [XLEN-1:0] mem_req_store_word;
  logic            mem_req_fulfilled;
  logic [XLEN-1:0] mem_req_loaded_word;

  modport slave (
    input  i_req_valid, i_req_size, i_req_address,
    output i_req_fulfilled, i_req_loaded_word,
    input  d_req_valid, d_req_operation, d_req_size, d_req_address, d_req_store_word,
    output d_req_fulfilled, d_req_loaded_word,
    output mem_req_valid, mem_req_operation, mem_req_size, mem_req_address, mem_req_store_word,
    input  mem_req_fulfilled, mem_req_loaded_word
  );

  modport master (
    output i_req_valid, i_req_size, i_req_address,
    input  i_req_fulfilled, i_req_loaded_word,
    output d_req_valid, d_req_operation, d_req_size, d_req_address, d_req_store_word,
    input  d_req_fulfilled, d_req_loaded_word,
    input  mem_req_valid, mem_req_operation, mem_req_size, mem_req_address, mem_req_store_word,
    output mem_req_fulfilled, mem_req_loaded_word
  );
endinterface

// File: rtl/hmem_arbiter.sv
// Two-requester (I-cache / D-cache) round-robin arbiter onto one higher-memory port.
// Optional line locking keeps a bursting owner granted: define HMEM_ARB_LINE_LOCK_EN.
module hmem_arbiter #(
  parameter int XLEN           = 32,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic          clk,
  input  logic          reset,
  hmem_arbiter_if.slave bus
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t state_reg;
  logic   owner_reg;
  logic   d_prio_reg;   // 1: D wins the next simultaneous request
  logic   grant_any;
  logic   rr_owner;
  logic   grant_owner;
  logic   fulfill;

`ifdef HMEM_ARB_LINE_LOCK_EN
  localparam int CNT_W = $clog2(WORDS_PER_LINE) + 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(WORDS_PER_LINE - 1);

  logic [CNT_W-1:0] lock_cnt_reg;
  logic             owner_valid;
  logic             lock_hold;
`endif

  assign grant_any = bus.i_req_valid | bus.d_req_valid;
  assign rr_owner  = (bus.i_req_valid && bus.d_req_valid) ? d_prio_reg : bus.d_req_valid;

`ifdef HMEM_ARB_LINE_LOCK_EN
  // A nonzero count means the last owner is mid-line and keeps priority while still asking.
  assign owner_valid = (owner_reg == OWN_D) ? bus.d_req_valid : bus.i_req_valid;
  assign lock_hold   = (lock_cnt_reg != '0) && owner_valid;
  assign grant_owner = lock_hold ? owner_reg : rr_owner;
`else
  assign grant_owner = rr_owner;
`endif

  // Response is a same-cycle pass-through; reset abandons any in-flight transaction.
  assign fulfill = (state_reg == ISSUE) && bus.mem_req_fulfilled && !reset;

  assign bus.i_req_fulfilled   = fulfill && (owner_reg == OWN_I);
  assign bus.d_req_fulfilled   = fulfill && (owner_reg == OWN_D);
  assign bus.i_req_loaded_word = bus.mem_req_loaded_word;
  assign bus.d_req_loaded_word = bus.mem_req_loaded_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg              <= IDLE;
      owner_reg              <= OWN_I;
      d_prio_reg             <= 1'b0;
      bus.mem_req_valid      <= 1'b0;
      bus.mem_req_operation  <= 1'b0;
      bus.mem_req_size       <= '0;
      bus.mem_req_address    <= '0;
      bus.mem_req_store_word <= '0;
`ifdef HMEM_ARB_LINE_LOCK_EN
      lock_cnt_reg           <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
`ifdef HMEM_ARB_LINE_LOCK_EN
          if ((lock_cnt_reg != '0) && !owner_valid) begin
            lock_cnt_reg <= '0;
          end
`endif
          if (grant_any) begin
            state_reg         <= ISSUE;
            owner_reg         <= grant_owner;
            d_prio_reg        <= (grant_owner == OWN_I);
            bus.mem_req_valid <= 1'b1;
            if (grant_owner == OWN_D) begin
              bus.mem_req_operation  <= bus.d_req_operation;
              bus.mem_req_size       <= bus.d_req_size;
              bus.mem_req_address    <= bus.d_req_address;
              bus.mem_req_store_word <= bus.d_req_store_word;
            end else begin
              bus.mem_req_operation  <= 1'b0;
              bus.mem_req_size       <= bus.i_req_size;
              bus.mem_req_address    <= bus.i_req_address;
              bus.mem_req_store_word <= '0;
            end
          end
        end
        ISSUE: begin
          if (bus.mem_req_fulfilled) begin
            state_reg         <= IDLE;
            bus.mem_req_valid <= 1'b0;
`ifdef HMEM_ARB_LINE_LOCK_EN
            lock_cnt_reg <= (lock_cnt_reg == LOCK_LAST) ? '0 : lock_cnt_reg + 1'b1;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hmem_arbiter.sv
// Directed bench for hmem_arbiter: a vector table of lone transactions plus
// hand-written sequences for arbitration order, reset abandonment and stray responses.
module tb_hmem_arbiter;

  localparam int XLEN = 32;
  localparam int WPL  = 8;
  localparam logic [31:0] I_ADDR = 32'h0000_0100;
  localparam logic [31:0] D_ADDR = 32'h0000_0200;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hmem_arbiter_if #(.XLEN(XLEN)) bus ();

  hmem_arbiter #(
    .XLEN(XLEN),
    .WORDS_PER_LINE(WPL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int i_pulses = 0;
  int d_pulses = 0;

  always @(posedge clk) begin
    if (bus.i_req_fulfilled === 1'b1) i_pulses <= i_pulses + 1;
    if (bus.d_req_fulfilled === 1'b1) d_pulses <= d_pulses + 1;
  end

  typedef struct {
    bit          use_d;
    bit          op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    bit          exp_op;
    logic [1:0]  exp_size;
    logic [31:0] exp_addr;
    logic [31:0] exp_store;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_req_valid         = 1'b0;
    bus.i_req_size          = 2'd0;
    bus.i_req_address       = '0;
    bus.d_req_valid         = 1'b0;
    bus.d_req_operation     = 1'b0;
    bus.d_req_size          = 2'd0;
    bus.d_req_address       = '0;
    bus.d_req_store_word    = '0;
    bus.mem_req_fulfilled   = 1'b0;
    bus.mem_req_loaded_word = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called on a negedge; returns on the negedge where mem_req_valid is seen high.
  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.mem_req_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("grant_timeout", 32'd0, 32'd1);
  endtask

  // Serves the current grant with one-cycle memory latency and reports its owner.
  task automatic serve_next(input bit drop_i, input bit drop_d, output bit is_d);
    bit ok;
    wait_grant(ok);
    is_d = (bus.mem_req_address == D_ADDR);
    bus.mem_req_fulfilled   = 1'b1;
    bus.mem_req_loaded_word = is_d ? 32'hD0D0_0001 : 32'h1111_0001;
    if (drop_i && !is_d) bus.i_req_valid = 1'b0;
    if (drop_d && is_d)  bus.d_req_valid = 1'b0;
    #1;
    check("serve_i_fulfilled", {31'd0, bus.i_req_fulfilled}, {31'd0, !is_d});
    check("serve_d_fulfilled", {31'd0, bus.d_req_fulfilled}, {31'd0, is_d});
    @(negedge clk);
    bus.mem_req_fulfilled = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  i0, d0;
    bit  is_d;
    bit  exp_order[10];

    vecs[0] = '{1'b1, 1'b1, 2'd2, 32'h1000_0040, 32'hDEAD_BEEF, 3, 32'h0000_0000,
                1'b1, 2'd2, 32'h1000_0040, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 2'd2, 32'h0000_2000, 32'hFFFF_FFFF, 2, 32'h1234_5678,
                1'b0, 2'd2, 32'h0000_2000, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 2'd1, 32'h2000_0004, 32'h5555_AAAA, 1, 32'hCAFE_F00D,
                1'b0, 2'd1, 32'h2000_0004, 32'h5555_AAAA};
    vecs[3] = '{1'b0, 1'b0, 2'd0, 32'hFFFF_FFFC, 32'h0000_0000, 4, 32'hA5A5_5A5A,
                1'b0, 2'd0, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[4] = '{1'b1, 1'b1, 2'd3, 32'h0000_0008, 32'h0BAD_F00D, 1, 32'h0000_0000,
                1'b1, 2'd3, 32'h0000_0008, 32'h0BAD_F00D};

    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("reset_mem_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    check("reset_mem_op",    {31'd0, bus.mem_req_operation}, 32'd0);
    check("reset_mem_size",  {30'd0, bus.mem_req_size}, 32'd0);
    check("reset_mem_addr",  bus.mem_req_address, 32'd0);
    check("reset_mem_store", bus.mem_req_store_word, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Lone transactions from the table.
    for (int v = 0; v < 5; v++) begin
      i0 = i_pulses;
      d0 = d_pulses;
      if (vecs[v].use_d) begin
        bus.d_req_valid      = 1'b1;
        bus.d_req_operation  = vecs[v].op;
        bus.d_req_size       = vecs[v].size;
        bus.d_req_address    = vecs[v].addr;
        bus.d_req_store_word = vecs[v].wdata;
      end else begin
        bus.i_req_valid      = 1'b1;
        bus.i_req_size       = vecs[v].size;
        bus.i_req_address    = vecs[v].addr;
        bus.d_req_operation  = vecs[v].op;
        bus.d_req_store_word = vecs[v].wdata;
      end
      @(negedge clk);
      check($sformatf("v%0d_latency1", v), {31'd0, bus.mem_req_valid}, 32'd1);
      check($sformatf("v%0d_op", v),    {31'd0, bus.mem_req_operation}, {31'd0, vecs[v].exp_op});
      check($sformatf("v%0d_size", v),  {30'd0, bus.mem_req_size}, {30'd0, vecs[v].exp_size});
      check($sformatf("v%0d_addr", v),  bus.mem_req_address, vecs[v].exp_addr);
      check($sformatf("v%0d_store", v), bus.mem_req_store_word, vecs[v].exp_store);
      repeat (vecs[v].lat - 1) @(negedge clk);
      check($sformatf("v%0d_hold_valid", v), {31'd0, bus.mem_req_valid}, 32'd1);
      check($sformatf("v%0d_hold_addr", v),  bus.mem_req_address, vecs[v].exp_addr);
      bus.mem_req_fulfilled   = 1'b1;
      bus.mem_req_loaded_word = vecs[v].rdata;
      bus.i_req_valid         = 1'b0;
      bus.d_req_valid         = 1'b0;
      #1;
      check($sformatf("v%0d_i_fulfilled", v), {31'd0, bus.i_req_fulfilled}, {31'd0, !vecs[v].use_d});
      check($sformatf("v%0d_d_fulfilled", v), {31'd0, bus.d_req_fulfilled}, {31'd0, vecs[v].use_d});
      check($sformatf("v%0d_i_word", v), bus.i_req_loaded_word, vecs[v].rdata);
      check($sformatf("v%0d_d_word", v), bus.d_req_loaded_word, vecs[v].rdata);
      @(negedge clk);
      bus.mem_req_fulfilled = 1'b0;
      check($sformatf("v%0d_valid_drop", v), {31'd0, bus.mem_req_valid}, 32'd0);
      check($sformatf("v%0d_i_pulses", v), i_pulses - i0, vecs[v].use_d ? 0 : 1);
      check($sformatf("v%0d_d_pulses", v), d_pulses - d0, vecs[v].use_d ? 1 : 0);
      $display("vector %0d: %s addr=0x%08h done", v, vecs[v].use_d ? "D" : "I", vecs[v].addr);
    end

    // Stray response while idle must be ignored.
    i0 = i_pulses;
    d0 = d_pulses;
    bus.mem_req_fulfilled = 1'b1;
    #1;
    check("stray_i_fulfilled", {31'd0, bus.i_req_fulfilled}, 32'd0);
    check("stray_d_fulfilled", {31'd0, bus.d_req_fulfilled}, 32'd0);
    @(negedge clk);
    bus.mem_req_fulfilled = 1'b0;
    check("stray_mem_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    bus.i_req_valid   = 1'b1;
    bus.i_req_address = I_ADDR;
    @(negedge clk);
    check("stray_then_grant", {31'd0, bus.mem_req_valid}, 32'd1);
    serve_next(1'b1, 1'b1, is_d);
    check("stray_pulses", (i_pulses - i0) + (d_pulses - d0), 32'd1);
    $display("stray fulfilled in idle: done");

    // Reset two cycles into ISSUE, with the response arriving just after.
    do_reset();
    i0 = i_pulses;
    d0 = d_pulses;
    bus.d_req_valid      = 1'b1;
    bus.d_req_operation  = 1'b1;
    bus.d_req_size       = 2'd2;
    bus.d_req_address    = 32'h1000_0040;
    bus.d_req_store_word = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.d_req_valid       = 1'b0;
    bus.mem_req_fulfilled = 1'b1;
    #1;
    check("rst_issue_d_fulfilled", {31'd0, bus.d_req_fulfilled}, 32'd0);
    check("rst_issue_i_fulfilled", {31'd0, bus.i_req_fulfilled}, 32'd0);
    check("rst_issue_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    check("rst_issue_op",    {31'd0, bus.mem_req_operation}, 32'd0);
    check("rst_issue_size",  {30'd0, bus.mem_req_size}, 32'd0);
    check("rst_issue_addr",  bus.mem_req_address, 32'd0);
    check("rst_issue_store", bus.mem_req_store_word, 32'd0);
    @(negedge clk);
    bus.mem_req_fulfilled = 1'b0;
    check("rst_issue_pulses", (i_pulses - i0) + (d_pulses - d0), 32'd0);
    $display("reset during issue: done");

    // Simultaneous requests after reset: I first, D in the very next IDLE cycle.
    do_reset();
    bus.i_req_valid   = 1'b1;
    bus.i_req_address = I_ADDR;
    bus.d_req_valid   = 1'b1;
    bus.d_req_address = D_ADDR;
    @(negedge clk);
    serve_next(1'b1, 1'b1, is_d);
    check("sim_first_owner_d", {31'd0, is_d}, 32'd0);
    check("b2b_idle_gap", {31'd0, bus.mem_req_valid}, 32'd0);
    @(negedge clk);
    check("b2b_grant", {31'd0, bus.mem_req_valid}, 32'd1);
    serve_next(1'b1, 1'b1, is_d);
    check("sim_second_owner_d", {31'd0, is_d}, 32'd1);
    $display("simultaneous request: I then D");

`ifdef HMEM_ARB_LINE_LOCK_EN
    // D bursts 9 words with I waiting: D x8, then I, then D.
    do_reset();
    bus.d_req_valid   = 1'b1;
    bus.d_req_address = D_ADDR;
    bus.i_req_address = I_ADDR;
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    for (int k = 0; k < 10; k++) exp_order[k] = (k != 8);
    for (int k = 0; k < 10; k++) begin
      serve_next(1'b1, 1'b0, is_d);
      check($sformatf("lock_grant%0d_is_d", k), {31'd0, is_d}, {31'd0, exp_order[k]});
      $display("lock grant %0d: %s", k, is_d ? "D" : "I");
    end
`else
    // Both valid continuously: strict alternation.
    do_reset();
    bus.i_req_valid   = 1'b1;
    bus.i_req_address = I_ADDR;
    bus.d_req_valid   = 1'b1;
    bus.d_req_address = D_ADDR;
    @(negedge clk);
    for (int k = 0; k < 4; k++) exp_order[k] = k[0];
    for (int k = 0; k < 4; k++) begin
      serve_next(1'b0, 1'b0, is_d);
      check($sformatf("rr_grant%0d_is_d", k), {31'd0, is_d}, {31'd0, exp_order[k]});
      $display("rr grant %0d: %s", k, is_d ? "D" : "I");
    end
`endif

    idle_inputs();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
